// File: rtl/point_frame_pkg.sv
// Shared constants, emit classification and default output bundle for point_frame_packer.
package point_frame_pkg;

    localparam int unsigned POINT_W_DEF          = 128;
    localparam int unsigned POINTS_PER_FRAME_DEF = 4;
    localparam int unsigned SEQ_W_DEF            = 16;
    localparam int unsigned FRAME_W_DEF          = POINT_W_DEF * POINTS_PER_FRAME_DEF;
    localparam int unsigned COUNT_W_DEF          = $clog2(POINTS_PER_FRAME_DEF + 1);

    typedef enum logic [1:0] {
        EMIT_NONE,
        EMIT_FULL,
        EMIT_PARTIAL
    } emit_kind_e;

    typedef struct packed {
        logic [FRAME_W_DEF-1:0] frame;
        logic [COUNT_W_DEF-1:0] count;
        logic [SEQ_W_DEF-1:0]   seq;
    } frame_bundle_t;

endpackage

// File: rtl/frame_out_reg.sv
// Single-entry valid/ready holding register for one frame bundle.
module frame_out_reg
    import point_frame_pkg::*;
#(
    parameter type bundle_t = frame_bundle_t
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  bundle_t load_data,
    input  logic    out_ready,
    output bundle_t out_data,
    output logic    out_valid,
    output logic    slot_free
);

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/point_frame_packer.sv
// Packs POINTS_PER_FRAME points into a frame word, newest point in the MSB slot.
// Define POINT_FRAME_PACKER_FLUSH_EN to enable partial-frame flush on the flush port.
module point_frame_packer
    import point_frame_pkg::*;
#(
    parameter int unsigned POINT_W          = POINT_W_DEF,
    parameter int unsigned POINTS_PER_FRAME = POINTS_PER_FRAME_DEF,
    parameter int unsigned SEQ_W            = SEQ_W_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [POINT_W-1:0]                    in_point,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  flush,
    output logic [POINT_W*POINTS_PER_FRAME-1:0]   out_frame,
    output logic [$clog2(POINTS_PER_FRAME+1)-1:0] out_count,
    output logic [SEQ_W-1:0]                      out_seq,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int unsigned FRAME_W = POINT_W * POINTS_PER_FRAME;
    localparam int unsigned CNT_W   = $clog2(POINTS_PER_FRAME + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(POINTS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(POINTS_PER_FRAME);

    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        logic [CNT_W-1:0]   count;
        logic [SEQ_W-1:0]   seq;
    } out_bundle_t;

    logic [FRAME_W-1:0] acc;
    logic [FRAME_W-1:0] shifted;
    logic [CNT_W-1:0]   cnt;
    logic [SEQ_W-1:0]   seq;
    logic               accept;
    logic               slot_free;
    emit_kind_e         kind;
    out_bundle_t        load_data;
    out_bundle_t        held;

    assign in_ready = !reset && (cnt != LAST || slot_free);
    assign accept   = in_valid && in_ready;
    assign shifted  = {in_point, acc[FRAME_W-1:POINT_W]};

`ifdef POINT_FRAME_PACKER_FLUSH_EN
    logic             flush_pend;
    logic [CNT_W-1:0] fill;

    assign fill = cnt + CNT_W'(accept);

    // A fresh pulse always re-arms; otherwise pend drops once serviced or found empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= flush || (flush_pend && kind == EMIT_NONE && fill != '0);
        end
    end

    always_comb begin
        kind = EMIT_NONE;
        if (accept && cnt == LAST) begin
            kind = EMIT_FULL;
        end else if (flush_pend && fill != '0 && slot_free) begin
            kind = EMIT_PARTIAL;
        end
    end

    always_comb begin
        load_data       = '0;
        load_data.frame = accept ? shifted : acc;
        load_data.count = (kind == EMIT_FULL) ? FULL : fill;
        load_data.seq   = seq;
    end
`else
    logic unused_flush;
    logic unused_acc_lsb;

    assign unused_flush   = flush;
    assign unused_acc_lsb = ^acc[POINT_W-1:0];

    always_comb begin
        kind = EMIT_NONE;
        if (accept && cnt == LAST) begin
            kind = EMIT_FULL;
        end
    end

    always_comb begin
        load_data       = '0;
        load_data.frame = shifted;
        load_data.count = FULL;
        load_data.seq   = seq;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            seq <= '0;
        end else if (kind != EMIT_NONE) begin
            acc <= '0;
            cnt <= '0;
            seq <= seq + SEQ_W'(1);
        end else if (accept) begin
            acc <= shifted;
            cnt <= cnt + CNT_W'(1);
        end
    end

    frame_out_reg #(
        .bundle_t(out_bundle_t)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (kind != EMIT_NONE),
        .load_data (load_data),
        .out_ready (out_ready),
        .out_data  (held),
        .out_valid (out_valid),
        .slot_free (slot_free)
    );

    assign out_frame = held.frame;
    assign out_count = held.count;
    assign out_seq   = held.seq;

endmodule
